// File: rtl/cmd_if.sv
// cmd_if: command handshake bus carrying {mode, load value, run length} into the sequencer
interface cmd_if #(parameter int LEN_W = 8);
  logic             valid;
  logic             ready;
  logic [1:0]       modo;
  logic [3:0]       d;
  logic [LEN_W-1:0] len;
  modport master (output valid, modo, d, len, input ready);
  modport slave  (input valid, modo, d, len, output ready);
endinterface

// File: rtl/counter_sequencer.sv
// counter_sequencer: FIFO-buffered command player driving ENABLE/MODO/D of a 4-bit mode counter.
// Define SEQ_CARRY_CNT_EN to add the saturating RCO carry counter and its carry_cnt output.
module counter_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_W      = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  cmd_if.slave                          cmd,
  input  logic                          abort,
  input  logic                          rco,
  output logic                          enable,
  output logic [1:0]                    modo,
  output logic [3:0]                    d,
  output logic                          cnt_rst,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(FIFO_DEPTH):0]   level
`ifdef SEQ_CARRY_CNT_EN
  ,
  output logic [7:0]                    carry_cnt
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nx;
  logic [1:0]       mem_modo [FIFO_DEPTH];
  logic [3:0]       mem_d    [FIFO_DEPTH];
  logic [LEN_W-1:0] mem_len  [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [LEN_W-1:0] rem;
  logic             push, pop, last;
  assign cmd.ready = (level != FULL) && !abort;
  assign push      = cmd.valid && cmd.ready;
  assign last      = (state == RUN) && (rem == LEN_W'(1));
  assign enable    = (state == RUN);
  assign busy      = (state == RUN);
  always_comb begin
    pop      = (level != '0) && (state == IDLE || last);
    state_nx = (state == IDLE || last) ? ((level != '0) ? RUN : IDLE) : state;
    state_nx = abort ? IDLE : state_nx;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  always_ff @(posedge clk)
    if (push) begin
      mem_modo[wr_ptr] <= cmd.modo;
      mem_d[wr_ptr]    <= cmd.d;
      mem_len[wr_ptr]  <= cmd.len;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      modo    <= '0;
      d       <= '0;
      rem     <= '0;
      done    <= 1'b0;
      cnt_rst <= 1'b1;
    end else begin
      cnt_rst <= abort;
      done    <= last && !abort;
      if (abort) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        // a zero length still plays one enabled cycle
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
          modo   <= mem_modo[rd_ptr];
          d      <= mem_d[rd_ptr];
          rem    <= (mem_len[rd_ptr] == '0) ? LEN_W'(1) : mem_len[rd_ptr];
        end else if (state == RUN) rem <= rem - 1'b1;
        level <= level + (AW+1)'(push) - (AW+1)'(pop);
      end
    end
`ifdef SEQ_CARRY_CNT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                         carry_cnt <= '0;
    else if (abort)                     carry_cnt <= '0;
    else if (rco && carry_cnt != 8'hFF) carry_cnt <= carry_cnt + 1'b1;
`else
  logic unused_rco;
  assign unused_rco = rco;
`endif
endmodule

// File: tb/tb_counter_sequencer.sv
// tb_counter_sequencer: directed and randomized checks of counter_sequencer against a command-stream model.
module tb_counter_sequencer;
  logic       clk = 0, rst_n = 1, abort = 0, rco = 0;
  logic       enable, cnt_rst, busy, done;
  logic [1:0] modo;
  logic [3:0] d;
  logic [2:0] level;
`ifdef SEQ_CARRY_CNT_EN
  logic [7:0] carry_cnt;
`endif
  cmd_if #(.LEN_W(8)) c();
  counter_sequencer #(.FIFO_DEPTH(4), .LEN_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .cmd(c), .abort(abort), .rco(rco),
    .enable(enable), .modo(modo), .d(d), .cnt_rst(cnt_rst),
    .busy(busy), .done(done), .level(level)
`ifdef SEQ_CARRY_CNT_EN
    , .carry_cnt(carry_cnt)
`endif
  );
  always #5 clk = ~clk;
  int         vectors = 0, miscompares = 0;
  logic [5:0] exp_q[$], obs_q[$];
  int         done_cnt = 0, en_rises = 0, busy_err = 0, cm = 0;
  logic       en_prev = 0;
  bit         mon = 0, rnd_rco = 0;
  // every enabled cycle is recorded as {modo,d}; the model predicts the same stream per command
  always @(negedge clk) begin
    if (mon) begin
      if (enable) obs_q.push_back({modo, d});
      if (done) done_cnt++;
      if (enable && !en_prev) en_rises++;
      if (busy !== enable) busy_err++;
    end
    en_prev = enable;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  function automatic void expect_cmd(input logic [1:0] m, input logic [3:0] dd, input int len);
    for (int i = 0; i < (len == 0 ? 1 : len); i++) exp_q.push_back({m, dd});
  endfunction
  task automatic step();
    @(posedge clk);
    if (abort) cm = 0;
    else if (rco && cm < 255) cm++;
    #1;
    if (rnd_rco) rco = 1'($urandom_range(0, 1));
  endtask
  task automatic clear_mon();
    obs_q.delete();
    exp_q.delete();
    done_cnt = 0;
    en_rises = 0;
  endtask
  task automatic push_cmd(input logic [1:0] m, input logic [3:0] dd, input logic [7:0] len);
    int b = 0;
    c.valid = 1; c.modo = m; c.d = dd; c.len = len;
    while (!c.ready && b < 400) begin step(); b++; end
    chk("push_accept", c.ready, 1);
    expect_cmd(m, dd, len);
    step();
    c.valid = 0;
  endtask
  task automatic wait_idle(input string tag);
    int b = 0;
    while ((busy || level != 0) && b < 1000) begin step(); b++; end
    step();
    chk({tag, "_idle"}, busy, 0);
  endtask
  task automatic cmp_stream(input string tag);
    int bad = 0;
    chk({tag, "_cycles"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) if (obs_q[i] !== exp_q[i]) bad++;
    chk({tag, "_data"}, bad, 0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [1:0] fm [5] = '{2, 1, 0, 3, 2};
    logic [3:0] fd [5] = '{3, 4, 5, 6, 7};
    logic [7:0] fl [5] = '{0, 0, 2, 0, 1};
    int st;
    c.valid = 0; c.modo = 0; c.d = 0; c.len = 0;
    #1 rst_n = 0;
    #1;
    chk("rst_enable", enable, 0);
    chk("rst_modo", modo, 0);
    chk("rst_d", d, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_level", level, 0);
    chk("rst_cnt_rst", cnt_rst, 1);
    chk("rst_ready", c.ready, 1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    chk("cnt_rst_hold", cnt_rst, 1);
    step();
    chk("cnt_rst_release", cnt_rst, 0);
    chk("ready_after_rst", c.ready, 1);
    mon = 1;
    // single command
    clear_mon();
    push_cmd(2'b10, 4'd0, 8'd5);
    chk("single_level", level, 1);
    chk("single_en_pre", enable, 0);
    step();
    chk("single_en_start", enable, 1);
    wait_idle("single");
    cmp_stream("single");
    chk("single_done", done_cnt, 1);
    chk("single_runs", en_rises, 1);
    // back-to-back
    clear_mon();
    push_cmd(2'b11, 4'd9, 8'd2);
    push_cmd(2'b01, 4'd0, 8'd3);
    wait_idle("b2b");
    cmp_stream("b2b");
    chk("b2b_done", done_cnt, 2);
    chk("b2b_runs", en_rises, 1);
    // full FIFO behind a long command
    clear_mon();
    push_cmd(2'b00, 4'd1, 8'd200);
    step();
    step();
    for (int i = 0; i < 4; i++) push_cmd(fm[i], fd[i], fl[i]);
    chk("full_level", level, 4);
    chk("full_ready", c.ready, 0);
    c.valid = 1; c.modo = fm[4]; c.d = fd[4]; c.len = fl[4];
    st = 0;
    while (!c.ready && st < 400) begin step(); st++; end
    chk("full_stall", st > 150, 1);
    chk("full_level_after_pop", level, 3);
    expect_cmd(fm[4], fd[4], fl[4]);
    step();
    c.valid = 0;
    wait_idle("full");
    cmp_stream("full");
    chk("full_done", done_cnt, 6);
    chk("full_runs", en_rises, 1);
    // abort mid-run
    clear_mon();
    push_cmd(2'b00, 4'd2, 8'd50);
    push_cmd(2'b01, 4'd3, 8'd10);
    push_cmd(2'b10, 4'd4, 8'd10);
    push_cmd(2'b11, 4'd5, 8'd10);
    chk("abort_level_pre", level, 3);
    chk("abort_en_pre", enable, 1);
    abort = 1; c.valid = 1; c.modo = 2'b01; c.d = 4'd7; c.len = 8'd4;
    #1;
    chk("abort_ready", c.ready, 0);
    step();
    abort = 0; c.valid = 0;
    chk("abort_enable", enable, 0);
    chk("abort_busy", busy, 0);
    chk("abort_level", level, 0);
    chk("abort_cnt_rst", cnt_rst, 1);
    chk("abort_done", done, 0);
    step();
    chk("abort_cnt_rst_once", cnt_rst, 0);
    chk("abort_level_after", level, 0);
    chk("abort_enable_after", enable, 0);
    repeat (3) step();
    chk("abort_no_done", done_cnt, 0);
    // asynchronous reset mid-run
    push_cmd(2'b10, 4'd5, 8'd20);
    step();
    step();
    chk("midrst_en_pre", enable, 1);
    rst_n = 0;
    cm = 0;
    #1;
    chk("midrst_enable", enable, 0);
    chk("midrst_cnt_rst", cnt_rst, 1);
    chk("midrst_modo", modo, 0);
    chk("midrst_d", d, 0);
    chk("midrst_level", level, 0);
    step();
    rst_n = 1;
    step();
    chk("midrst_release", cnt_rst, 0);
    chk("midrst_idle", enable, 0);
`ifdef SEQ_CARRY_CNT_EN
    chk("carry_zero", carry_cnt, 0);
    rco = 1;
    repeat (10) step();
    chk("carry_10", carry_cnt, 10);
    repeat (290) step();
    chk("carry_sat", carry_cnt, 255);
    rco = 0; abort = 1;
    step();
    abort = 0;
    chk("carry_abort", carry_cnt, 0);
`endif
    // randomized command stream
    clear_mon();
    rnd_rco = 1;
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 2)) step();
      push_cmd(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 6)));
    end
    wait_idle("rand");
    cmp_stream("rand");
    chk("rand_done", done_cnt, 40);
`ifdef SEQ_CARRY_CNT_EN
    chk("rand_carry", carry_cnt, cm);
`endif
    rnd_rco = 0;
    chk("busy_tracks_enable", busy_err, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
